// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared fetch state type and processor-wide address defaults
package proc_pkg;

  // Fetch sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Defaults shared by the instruction ROM and the top level
  localparam int PROC_A          = 10;
  localparam int PROC_START_ADDR = 0;
  localparam int PROC_CW         = 16;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC selection (stall > halt > branch > increment)
module pc_next
  import proc_pkg::*;
#(
  parameter int A = PROC_A
) (
  input  logic [A-1:0] pc,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic [A-1:0] branch_tgt,
  output logic [A-1:0] pc_nxt,
  output logic         halt_take
);

  localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

  // Priority mux; A-bit adds wrap naturally, so a two's-complement offset
  // added without extension equals the sign-extended sum mod 2^A
  always_comb begin
    pc_nxt    = pc;
    halt_take = 1'b0;
    if (stall) begin
      pc_nxt = pc;
    end else if (halt) begin
      halt_take = 1'b1;
    end else if (branch_en) begin
      pc_nxt = branch_rel ? (pc + branch_tgt) : branch_tgt;
    end else begin
      pc_nxt = pc + ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter FSM with start/done handshake and cycle counter
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter int A          = PROC_A,
  parameter int START_ADDR = PROC_START_ADDR,
  parameter int CW         = PROC_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  logic [A-1:0]  branch_tgt,
  output logic [A-1:0]  instr_address,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_count
);

  localparam logic [A-1:0]  START_PC = A'(START_ADDR);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  fetch_state_t  state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic [A-1:0]  pc_run;
  logic          halt_take;

  pc_next #(.A(A)) u_pc_next (
    .pc         (pc_q),
    .stall      (stall),
    .halt       (halt),
    .branch_en  (branch_en),
    .branch_rel (branch_rel),
    .branch_tgt (branch_tgt),
    .pc_nxt     (pc_run),
    .halt_take  (halt_take)
  );

  // Next-state, PC and counter; running/done are decoded from the next state
  // so that they come straight out of flops
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d = START_PC;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        pc_d  = pc_run;
        if (halt_take) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
        cnt_d   = '0;
      end
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign instr_address = pc_q;
  assign running       = running_q;
  assign done          = done_q;
  assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with directed vectors
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, stall, halt, branch_en, branch_rel;
  logic [9:0]  branch_tgt;
  logic [9:0]  instr_address;
  logic        running, done;
  logic [15:0] cycle_count;

  typedef struct {
    string       name;
    logic [9:0]  addr;
    logic        run;
    logic        dn;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  event chk_ev;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .halt          (halt),
    .branch_en     (branch_en),
    .branch_rel    (branch_rel),
    .branch_tgt    (branch_tgt),
    .instr_address (instr_address),
    .running       (running),
    .done          (done),
    .cycle_count   (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on each falling edge (or an explicit mid-cycle check) pop one expectation
  always begin
    @(negedge clk or chk_ev);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (instr_address !== e.addr || running !== e.run || done !== e.dn || cycle_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got addr=%h run=%b done=%b cnt=%0d, expected addr=%h run=%b done=%b cnt=%0d",
                 e.name, instr_address, running, done, cycle_count, e.addr, e.run, e.dn, e.cnt);
      end
    end
  end

  task automatic push(input string nm, input logic [9:0] a, input logic r, input logic d,
                      input logic [15:0] c);
    exp_t e;
    e.name = nm; e.addr = a; e.run = r; e.dn = d; e.cnt = c;
    sb.push_back(e);
  endtask

  // One clock: drive inputs, push post-edge expectation, return at next falling edge
  task automatic cyc(input string nm, input logic st, input logic sl, input logic hl,
                     input logic be, input logic br, input logic [9:0] tg,
                     input logic [9:0] ea, input logic er, input logic ed, input logic [15:0] ec);
    start = st; stall = sl; halt = hl; branch_en = be; branch_rel = br; branch_tgt = tg;
    @(posedge clk);
    #1;
    push(nm, ea, er, ed, ec);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 0; stall = 0; halt = 0; branch_en = 0; branch_rel = 0; branch_tgt = '0;
    #2;
    push("reset", 10'h000, 0, 0, 16'd0);
    -> chk_ev;
    @(negedge clk);
    rst_n = 1'b1;

    //   name          st sl hl be br tgt      addr    run dn cnt
    cyc("idle",        0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 16'd0);
    cyc("start",       1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 16'd0);
    cyc("inc1",        0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 16'd1);
    cyc("inc2",        0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 16'd2);
    cyc("inc3",        0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 16'd3);
    cyc("inc4",        0, 0, 0, 0, 0, 10'h000, 10'h004, 1, 0, 16'd4);
    cyc("inc5",        0, 0, 0, 0, 0, 10'h000, 10'h005, 1, 0, 16'd5);
    cyc("halt5",       0, 0, 1, 0, 0, 10'h000, 10'h005, 0, 1, 16'd6);
    cyc("done_hold",   0, 1, 1, 1, 0, 10'h155, 10'h005, 0, 1, 16'd6);
    cyc("restart",     1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 16'd0);
    cyc("start_in_run",1, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 16'd1);
    cyc("r2",          0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 16'd2);
    cyc("r3",          0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 16'd3);
    cyc("r4",          0, 0, 0, 0, 0, 10'h000, 10'h004, 1, 0, 16'd4);
    cyc("abs_3f0",     0, 0, 0, 1, 0, 10'h3F0, 10'h3F0, 1, 0, 16'd5);
    cyc("after_abs",   0, 0, 0, 0, 0, 10'h000, 10'h3F1, 1, 0, 16'd6);
    cyc("abs_8",       0, 0, 0, 1, 0, 10'h008, 10'h008, 1, 0, 16'd7);
    cyc("rel_m3",      0, 0, 0, 1, 1, 10'h3FD, 10'h005, 1, 0, 16'd8);
    cyc("rel_0_loop",  0, 0, 0, 1, 1, 10'h000, 10'h005, 1, 0, 16'd9);
    cyc("abs_0",       0, 0, 0, 1, 0, 10'h000, 10'h000, 1, 0, 16'd10);
    cyc("rel_m1_wrap", 0, 0, 0, 1, 1, 10'h3FF, 10'h3FF, 1, 0, 16'd11);
    cyc("inc_wrap",    0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 16'd12);
    cyc("stall1",      0, 1, 1, 1, 0, 10'h123, 10'h000, 1, 0, 16'd13);
    cyc("stall2",      0, 1, 1, 1, 0, 10'h123, 10'h000, 1, 0, 16'd14);
    cyc("stall3",      0, 1, 1, 1, 0, 10'h123, 10'h000, 1, 0, 16'd15);
    cyc("stall_rel",   0, 0, 0, 1, 0, 10'h123, 10'h123, 1, 0, 16'd16);
    cyc("rel_p5",      0, 0, 0, 1, 1, 10'h005, 10'h128, 1, 0, 16'd17);
    cyc("halt128",     0, 0, 1, 1, 0, 10'h000, 10'h128, 0, 1, 16'd18);
    cyc("done_freeze", 0, 0, 0, 0, 0, 10'h000, 10'h128, 0, 1, 16'd18);
    cyc("restart2",    1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 16'd0);
    cyc("r2_1",        0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 16'd1);
    cyc("r2_2",        0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 16'd2);

    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 10'h000, 0, 0, 16'd0);
    -> chk_ev;
    @(posedge clk);
    #1;
    push("in_reset", 10'h000, 0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc("post_idle1",  0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 16'd0);
    cyc("post_idle2",  0, 1, 1, 1, 0, 10'h0AA, 10'h000, 0, 0, 16'd0);
    cyc("post_start",  1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 16'd0);
    cyc("post_inc",    0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 16'd1);

    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
